clock_stepper: RTL and testbench
================================

CLOCK_STEPPER -- requirements
Module: clock_stepper

Interface
Parameters:
REQ-001 SHALL have parameter PULSE_LEN, default 4: clk_kit cycles clk_out stays high per single step; legal range 1..255.
REQ-002 SHALL have parameter HALF_DIV, default 8: clk_kit cycles per half-period in run mode; legal range 1..255.
Ports (name, direction, width, meaning):
REQ-003 SHALL have port clk_kit, input, 1: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port btn_in, input, 1: already-filtered, clk_kit-synchronous step-button level.
REQ-006 SHALL have port run_mode, input, 1: 1 = free-running clock, 0 = single-step.
REQ-007 SHALL have port clk_out, output, 1: generated processor clock, driven directly from a flop.
REQ-008 SHALL have port busy, output, 1: 1 whenever the state is not IDLE.
REQ-009 SHALL have port step_count, output, 8: count of clk_out rising edges generated.

Function
REQ-010 SHALL implement states IDLE, PULSE, WAIT_REL, RUN_HI and RUN_LO.
REQ-011 SHALL register btn_in every cycle into btn_prev; rise = btn_in AND NOT btn_prev.
REQ-012 IDLE: clk_out=0; run_mode=1 -> RUN_HI; else rise=1 -> PULSE; else stay.
REQ-013 SHALL give run_mode priority over rise when both occur in the same IDLE cycle; that edge is discarded.
REQ-014 PULSE: clk_out=1 for exactly PULSE_LEN cycles, first high cycle being the one after the cycle where rise=1 (latency 1).
REQ-015 End of PULSE: btn_in=1 -> WAIT_REL, btn_in=0 -> IDLE; clk_out=0 from the next cycle either way.
REQ-016 WAIT_REL: clk_out=0; leave to IDLE when btn_in=0; ignore run_mode until back in IDLE.
REQ-017 A press shorter than PULSE_LEN SHALL still yield a full-length pulse; at most one pulse per rising edge of btn_in.
REQ-018 RUN_HI: clk_out=1 for HALF_DIV cycles, then RUN_LO; RUN_LO: clk_out=0 for HALF_DIV cycles.
REQ-019 End of RUN_LO: run_mode=1 -> RUN_HI, else IDLE; run_mode falling mid-period SHALL NOT shorten the current period.
REQ-020 btn_in SHALL be ignored in RUN_HI/RUN_LO; btn_prev keeps tracking, so a button held when run ends gives no pulse.
REQ-021 step_count SHALL increment by 1 on every PULSE and RUN_HI entry, wrapping 255 -> 0 without flag.
REQ-022 The phase counter SHALL be 8 bits, reloaded on each state entry; never count beyond the parameter value.

Reset
REQ-023 rst_n=0 SHALL immediately, without clock, force state=IDLE, clk_out=0, busy=0, step_count=0, phase counter=0, btn_prev=1.
REQ-024 btn_prev=1 at reset SHALL prevent a pulse when btn_in is already high at reset release; a new 0->1 transition is required.
REQ-025 Reset asserted mid-PULSE or mid-RUN_HI SHALL drop clk_out within the same cycle; first clk_kit edge after release evaluates IDLE.

Verification
REQ-026 Defaults, btn_in 0->1 held 10 cycles -> clk_out high exactly 4 cycles starting 1 cycle after rise, WAIT_REL until release, step_count=1.
REQ-027 btn_in high for 1 cycle only -> one 4-cycle pulse, state returns to IDLE, busy high exactly 4 cycles.
REQ-028 run_mode=1 for 40 cycles, then 0 -> clk_out period 16 (8 high/8 low), final period completed in full, step_count=3.
REQ-029 In IDLE, run_mode and btn rise in the same cycle -> RUN_HI entered, no PULSE generated at any time afterwards for that press.
REQ-030 btn_in held high through rst_n pulse -> no clk_out pulse after release; release then press -> exactly one pulse.
REQ-031 257 single steps -> step_count=1 (wrap); rst_n low during 3rd high cycle of a pulse -> clk_out=0 at once, step_count=0.

Source files
------------

// File: rtl/clock_stepper.sv
// Processor clock source for the lab kit: single-step pulses from a push button,
// or a free-running clock of period 2*HALF_DIV while run_mode is held.
module clock_stepper #(
   parameter int PULSE_LEN = 4,
   parameter int HALF_DIV  = 8
) (
   input  logic       clk_kit,
   input  logic       rst_n,
   input  logic       btn_in,
   input  logic       run_mode,
   output logic       clk_out,
   output logic       busy,
   output logic [7:0] step_count
);

   typedef enum logic [2:0] {
      IDLE,
      PULSE,
      WAIT_REL,
      RUN_HI,
      RUN_LO
   } state_t;

   localparam logic [7:0] PULSE_CYC = 8'(PULSE_LEN);
   localparam logic [7:0] HALF_CYC  = 8'(HALF_DIV);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] phase;
   logic [7:0] phase_nxt;
   logic       clk_nxt;
   logic       count_en;
   logic       btn_prev;
   logic       rise;
   logic       phase_done;

   assign rise       = btn_in & ~btn_prev;
   assign phase_done = (phase <= 8'd1);
   assign busy       = (state != IDLE);

   // phase counts down the cycles left in the current state; clk_nxt is the
   // value clk_out takes after the edge, so the output stays a plain flop
   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      clk_nxt   = 1'b0;
      count_en  = 1'b0;
      case (state)
         IDLE: begin
            if (run_mode) begin
               state_nxt = RUN_HI;
               phase_nxt = HALF_CYC;
               clk_nxt   = 1'b1;
               count_en  = 1'b1;
            end else if (rise) begin
               state_nxt = PULSE;
               phase_nxt = PULSE_CYC;
               clk_nxt   = 1'b1;
               count_en  = 1'b1;
            end
         end
         PULSE: begin
            if (phase_done) begin
               state_nxt = btn_in ? WAIT_REL : IDLE;
               phase_nxt = 8'd0;
            end else begin
               phase_nxt = phase - 8'd1;
               clk_nxt   = 1'b1;
            end
         end
         WAIT_REL: begin
            if (!btn_in) begin
               state_nxt = IDLE;
            end
         end
         RUN_HI: begin
            if (phase_done) begin
               state_nxt = RUN_LO;
               phase_nxt = HALF_CYC;
            end else begin
               phase_nxt = phase - 8'd1;
               clk_nxt   = 1'b1;
            end
         end
         RUN_LO: begin
            // run_mode is only sampled here, so a period is never cut short
            if (phase_done) begin
               if (run_mode) begin
                  state_nxt = RUN_HI;
                  phase_nxt = HALF_CYC;
                  clk_nxt   = 1'b1;
                  count_en  = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  phase_nxt = 8'd0;
               end
            end else begin
               phase_nxt = phase - 8'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            phase_nxt = 8'd0;
         end
      endcase
   end

   // btn_prev resets high so a button already held at release cannot step
   always_ff @(posedge clk_kit or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         phase      <= 8'd0;
         clk_out    <= 1'b0;
         step_count <= 8'd0;
         btn_prev   <= 1'b1;
      end else begin
         state    <= state_nxt;
         phase    <= phase_nxt;
         clk_out  <= clk_nxt;
         btn_prev <= btn_in;
         if (count_en) begin
            step_count <= step_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_clock_stepper.sv
// Bench for clock_stepper: directed scenarios plus random button/run traffic,
// all checked against a cycle-level behavioural model of the stepper.
module tb_clock_stepper;

   localparam int PULSE_LEN = 4;
   localparam int HALF_DIV  = 8;

   localparam int M_IDLE = 0;
   localparam int M_PULSE = 1;
   localparam int M_WAIT = 2;
   localparam int M_RUN = 3;

   logic       clk_kit;
   logic       rst_n;
   logic       btn_in;
   logic       run_mode;
   logic       clk_out;
   logic       busy;
   logic [7:0] step_count;

   int errors;
   int checks;

   int mMode;
   int mLeft;
   int mT;
   int mSteps;
   bit mPrev;

   int highCount;
   int busyCount;

   clock_stepper #(
      .PULSE_LEN(PULSE_LEN),
      .HALF_DIV (HALF_DIV)
   ) dut (
      .clk_kit   (clk_kit),
      .rst_n     (rst_n),
      .btn_in    (btn_in),
      .run_mode  (run_mode),
      .clk_out   (clk_out),
      .busy      (busy),
      .step_count(step_count)
   );

   initial clk_kit = 1'b0;
   always #5 clk_kit = ~clk_kit;

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      mMode = M_IDLE;
      mLeft = 0;
      mT = 0;
      mSteps = 0;
      mPrev = 1'b1;
   endtask

   // One rising edge of the model: a pulse is a countdown of remaining high
   // cycles, run mode is a position within a 2*HALF_DIV cycle period
   task automatic modelEdge();
      bit rise;
      rise = btn_in && !mPrev;
      case (mMode)
         M_IDLE: begin
            if (run_mode) begin
               mMode = M_RUN;
               mT = 0;
               mSteps = (mSteps + 1) % 256;
            end else if (rise) begin
               mMode = M_PULSE;
               mLeft = PULSE_LEN;
               mSteps = (mSteps + 1) % 256;
            end
         end
         M_PULSE: begin
            mLeft--;
            if (mLeft == 0) mMode = btn_in ? M_WAIT : M_IDLE;
         end
         M_WAIT: begin
            if (!btn_in) mMode = M_IDLE;
         end
         default: begin
            mT++;
            if (mT == 2 * HALF_DIV) begin
               if (run_mode) begin
                  mT = 0;
                  mSteps = (mSteps + 1) % 256;
               end else begin
                  mMode = M_IDLE;
               end
            end
         end
      endcase
      mPrev = btn_in;
   endtask

   function automatic int expClk();
      if (mMode == M_PULSE) return 1;
      if (mMode == M_RUN) return (mT < HALF_DIV) ? 1 : 0;
      return 0;
   endfunction

   task automatic applyStimulus();
      @(posedge clk_kit);
      if (rst_n) modelEdge();
      else modelReset();
      @(negedge clk_kit);
      checkOutput("clk_out", clk_out, expClk());
      checkOutput("busy", busy, (mMode != M_IDLE) ? 1 : 0);
      checkOutput("step_count", step_count, mSteps);
      highCount += clk_out;
      busyCount += busy;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   // Asserted between edges so the outputs must clear with no clock at all
   task automatic resetPulse();
      #2 rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("rst_async_clk", clk_out, 0);
      checkOutput("rst_async_busy", busy, 0);
      checkOutput("rst_async_steps", step_count, 0);
      runCycles(2);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      highCount = 0;
      busyCount = 0;
      rst_n = 1'b0;
      btn_in = 1'b0;
      run_mode = 1'b0;
      modelReset();
      #1;
      checkOutput("reset_clk", clk_out, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_steps", step_count, 0);
      runCycles(2);
      #1 rst_n = 1'b1;
      runCycles(2);

      // held press: one 4-cycle pulse, then wait for release
      highCount = 0;
      btn_in = 1'b1;
      runCycles(10);
      checkOutput("held_busy", busy, 1);
      btn_in = 1'b0;
      runCycles(3);
      checkOutput("held_high_cycles", highCount, PULSE_LEN);
      checkOutput("held_steps", step_count, 1);

      // one-cycle press still gives a full pulse
      busyCount = 0;
      btn_in = 1'b1;
      runCycles(1);
      btn_in = 1'b0;
      runCycles(8);
      checkOutput("short_busy_cycles", busyCount, PULSE_LEN);
      checkOutput("short_steps", step_count, 2);

      // free run for 40 cycles: three whole periods
      resetPulse();
      runCycles(2);
      highCount = 0;
      run_mode = 1'b1;
      runCycles(40);
      run_mode = 1'b0;
      runCycles(20);
      checkOutput("run_steps", step_count, 3);
      checkOutput("run_high_cycles", highCount, 3 * HALF_DIV);

      // run and press together: run wins, the press is lost
      resetPulse();
      runCycles(2);
      run_mode = 1'b1;
      btn_in = 1'b1;
      runCycles(5);
      run_mode = 1'b0;
      runCycles(30);
      checkOutput("prio_steps", step_count, 1);
      checkOutput("prio_busy", busy, 0);

      // button held across reset release must not step
      highCount = 0;
      resetPulse();
      runCycles(10);
      checkOutput("held_rst_high", highCount, 0);
      btn_in = 1'b0;
      runCycles(1);
      btn_in = 1'b1;
      runCycles(1);
      btn_in = 1'b0;
      runCycles(8);
      checkOutput("held_rst_steps", step_count, 1);

      // 257 steps wrap the counter, then reset lands mid-pulse
      resetPulse();
      runCycles(2);
      for (int p = 0; p < 257; p++) begin
         btn_in = 1'b1;
         runCycles(1);
         btn_in = 1'b0;
         runCycles(5);
      end
      checkOutput("wrap_steps", step_count, 1);
      btn_in = 1'b1;
      runCycles(3);
      checkOutput("mid_pulse_clk", clk_out, 1);
      resetPulse();
      btn_in = 1'b0;
      runCycles(3);

      // random button and run traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(3, 0) == 0) btn_in = ~btn_in;
         if ($urandom_range(39, 0) == 0) run_mode = ~run_mode;
         if ($urandom_range(599, 0) == 0) resetPulse();
         else applyStimulus();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
